ifetch_ctrl: RTL and testbench

Instruction-fetch controller that sequences the word-addressed instruction memory. It owns the program counter and drives the memory's combinational read address. It captures the returned word into a 2-entry fetch buffer and presents it to decode through a valid/ready handshake. It sits between the instruction memory and the decode stage, and handles start, branch/jump redirects and back-pressure.

---
 rtl/ifetch_pkg.sv | 16 +
 rtl/ifetch_buffer.sv | 77 +++++++
 rtl/ifetch_ctrl.sv | 113 +++++++++++
 tb/tb_ifetch_ctrl.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction-fetch controller.
// The halt word is only consulted when IFETCH_HALT_DETECT_EN is defined.
package ifetch_pkg;

  localparam int ADDR_W_DEF = 10;
  localparam int DATA_W_DEF = 32;

  localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_e;

endpackage

// File: rtl/ifetch_buffer.sv
// Two-entry in-order fetch buffer of {pc, instr}; slot 0 is always the head.
// Flush drops both entries; push and pop may coincide even when full.
module ifetch_buffer #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [ADDR_W-1:0] push_pc,
  input  logic [DATA_W-1:0] push_instr,
  input  logic              pop,
  input  logic              flush,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W-1:0] head_pc,
  output logic [DATA_W-1:0] head_instr
);

  logic [1:0]        vld_q, vld_d;
  logic [ADDR_W-1:0] pc_q    [2];
  logic [ADDR_W-1:0] pc_d    [2];
  logic [DATA_W-1:0] instr_q [2];
  logic [DATA_W-1:0] instr_d [2];

  always_comb begin
    // NOTE: every signal gets its hold value first so no path leaves it unassigned (no latch).
    vld_d   = vld_q;
    pc_d    = pc_q;
    instr_d = instr_q;

    if (flush) begin
      vld_d = 2'b00;
    end else begin
      if (pop) begin
        vld_d[0]   = vld_q[1];
        pc_d[0]    = pc_q[1];
        instr_d[0] = instr_q[1];
        vld_d[1]   = 1'b0;
      end
      // Write into the first free slot as seen after the pop, keeping order.
      if (push) begin
        if (!vld_d[0]) begin
          vld_d[0]   = 1'b1;
          pc_d[0]    = push_pc;
          instr_d[0] = push_instr;
        end else begin
          vld_d[1]   = 1'b1;
          pc_d[1]    = push_pc;
          instr_d[1] = push_instr;
        end
      end
    end
  end

  // NOTE: the two data slots are reset too, because the head must read as zero out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q      <= 2'b00;
      pc_q[0]    <= '0;
      pc_q[1]    <= '0;
      instr_q[0] <= '0;
      instr_q[1] <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      vld_q   <= vld_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  assign full       = vld_q[1];
  assign empty      = !vld_q[0];
  assign head_pc    = pc_q[0];
  assign head_instr = instr_q[0];

endmodule

// File: rtl/ifetch_ctrl.sv
// Instruction-fetch controller: PC, IDLE/RUN/HALT sequencing and redirects.
// Optional halt-word detection is enabled by defining IFETCH_HALT_DETECT_EN.
module ifetch_ctrl
  import ifetch_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int RESET_PC = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_instr,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_instr,
  output logic [ADDR_W-1:0] if_pc,
  input  logic              id_ready,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              halted
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              push, pop, flush;
  logic              buf_full, buf_empty;

`ifdef IFETCH_HALT_DETECT_EN
  logic halted_q, halted_d;
`endif

  assign pop = if_valid & id_ready;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    push    = 1'b0;
    flush   = 1'b0;
`ifdef IFETCH_HALT_DETECT_EN
    halted_d = halted_q;
`endif

    if (redirect_valid) begin
      // A concurrent pop is swallowed by the flush; IDLE deliberately stays IDLE.
      flush = 1'b1;
      pc_d  = redirect_pc;
      if (state_q == HALT) state_d = RUN;
`ifdef IFETCH_HALT_DETECT_EN
      halted_d = 1'b0;
`endif
    end else begin
      unique case (state_q)
        IDLE: if (start) state_d = RUN;
        RUN: begin
          if (!buf_full || pop) begin
            push = 1'b1;
            pc_d = pc_q + ADDR_W'(1);
`ifdef IFETCH_HALT_DETECT_EN
            if (imem_instr == DATA_W'(HALT_WORD)) begin
              state_d  = HALT;
              halted_d = 1'b1;
            end
`endif
          end
        end
        HALT: ;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= ADDR_W'(RESET_PC);
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

`ifdef IFETCH_HALT_DETECT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) halted_q <= 1'b0;
    else        halted_q <= halted_d;
  end
  assign halted = halted_q;
`else
  assign halted = 1'b0;
`endif

  assign imem_addr = pc_q;
  assign if_valid  = !buf_empty;

  ifetch_buffer #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_pc   (pc_q),
    .push_instr(imem_instr),
    .pop       (pop),
    .flush     (flush),
    .full      (buf_full),
    .empty     (buf_empty),
    .head_pc   (if_pc),
    .head_instr(if_instr)
  );

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Scoreboard bench for ifetch_ctrl: stimulus queues expected {pc, instr},
// a negedge monitor pops and compares on every accepted handshake.
module tb_ifetch_ctrl;

  localparam int AW = 10;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          id_ready = 1'b0;
  logic          redirect_valid = 1'b0;
  logic [AW-1:0] redirect_pc = '0;
  logic [AW-1:0] imem_addr;
  logic [DW-1:0] imem_instr;
  logic          if_valid;
  logic [DW-1:0] if_instr;
  logic [AW-1:0] if_pc;
  logic          halted;
  bit            halt_mode = 1'b0;

  typedef struct {
    logic [AW-1:0] pc;
    logic [DW-1:0] instr;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   n_cmp  = 0;
  int   n_fail = 0;
  int   nt;

  ifetch_ctrl #(.ADDR_W(AW), .DATA_W(DW), .RESET_PC(0)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .imem_addr     (imem_addr),
    .imem_instr    (imem_instr),
    .if_valid      (if_valid),
    .if_instr      (if_instr),
    .if_pc         (if_pc),
    .id_ready      (id_ready),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .halted        (halted)
  );

  always #5 clk = ~clk;

  // Memory model: word i = 0x0010_0000 + i, word 3 = halt word in halt_mode.
  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    if (halt_mode && a == AW'(3)) return 32'hFFFF_FFFF;
    return 32'h0010_0000 + DW'(a);
  endfunction

  assign imem_instr = (halt_mode && imem_addr == AW'(3)) ? 32'hFFFF_FFFF
                                                         : 32'h0010_0000 + DW'(imem_addr);

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  // Monitor: every handshake the DUT will honour is checked against the queue.
  always @(negedge clk) begin
    if (rst_n && if_valid && id_ready && !redirect_valid) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL spurious_pop: got pc 0x%0h, required no delivery", if_pc);
      end else begin
        e = exp_q.pop_front();
        check("sb_pc", 64'(if_pc), 64'(e.pc));
        check("sb_instr", 64'(if_instr), 64'(e.instr));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic do_redirect(input logic [AW-1:0] tgt);
    exp_q.delete();
    redirect_valid = 1'b1;
    redirect_pc    = tgt;
    tick();
    redirect_valid = 1'b0;
  endtask

  task automatic expect_seq(input logic [AW-1:0] pc0, input int n);
    exp_t x;
    logic [AW-1:0] p;
    p = pc0;
    for (int i = 0; i < n; i++) begin
      x.pc    = p;
      x.instr = mem_word(p);
      exp_q.push_back(x);
      p = p + AW'(1);
    end
  endtask

  // Hold id_ready high until the queue drains; returns cycles taken.
  task automatic drain(output int ticks);
    id_ready = 1'b1;
    ticks = 0;
    while (exp_q.size() != 0 && ticks < 30) begin
      tick();
      ticks++;
    end
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL drain_timeout: got %0d entries left, required 0", exp_q.size());
      exp_q.delete();
    end
    id_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    #3;
    check("rst_if_valid", 64'(if_valid), 64'(0));
    check("rst_if_instr", 64'(if_instr), 64'(0));
    check("rst_if_pc", 64'(if_pc), 64'(0));
    check("rst_imem_addr", 64'(imem_addr), 64'(0));
    check("rst_halted", 64'(halted), 64'(0));
    rst_n = 1'b1;
    tick();
    tick();
    tick();
    check("idle_no_fetch_valid", 64'(if_valid), 64'(0));
    check("idle_pc_held", 64'(imem_addr), 64'(0));

    // Streaming with id_ready = 1
    id_ready = 1'b1;
    pulse_start();
    check("start_edge_valid", 64'(if_valid), 64'(0));
    expect_seq(AW'(0), 4);
    drain(nt);
    check("stream_cycles", 64'(nt), 64'(5));
    check("stream_halted", 64'(halted), 64'(0));

    // Back-pressure
    do_reset();
    pulse_start();
    for (int i = 1; i <= 5; i++) begin
      tick();
      if (i >= 2) begin
        check("stall_imem_addr", 64'(imem_addr), 64'(2));
        check("stall_if_valid", 64'(if_valid), 64'(1));
        check("stall_if_pc", 64'(if_pc), 64'(0));
        check("stall_if_instr", 64'(if_instr), 64'(32'h0010_0000));
      end
    end
    expect_seq(AW'(0), 3);
    drain(nt);
    check("release_cycles", 64'(nt), 64'(3));
    tick();
    check("refill_full_valid", 64'(if_valid), 64'(1));

    // Redirect with a full buffer
    do_redirect(AW'(10'h200));
    check("redir_flush_valid", 64'(if_valid), 64'(0));
    check("redir_imem_addr", 64'(imem_addr), 64'(10'h200));
    expect_seq(AW'(10'h200), 2);
    drain(nt);
    check("redir_cycles", 64'(nt), 64'(3));

    // Redirect near the top of memory, wrap to 0
    id_ready = 1'b1;
    do_redirect(AW'(10'h3FE));
    check("wrap_flush_valid", 64'(if_valid), 64'(0));
    expect_seq(AW'(10'h3FE), 3);
    drain(nt);
    check("wrap_cycles", 64'(nt), 64'(4));

`ifdef IFETCH_HALT_DETECT_EN
    // Halt word at address 3
    halt_mode = 1'b1;
    do_reset();
    id_ready = 1'b1;
    pulse_start();
    expect_seq(AW'(0), 4);
    drain(nt);
    check("halt_cycles", 64'(nt), 64'(5));
    check("halt_halted", 64'(halted), 64'(1));
    check("halt_pc", 64'(imem_addr), 64'(4));
    check("halt_empty", 64'(if_valid), 64'(0));
    tick();
    tick();
    tick();
    check("halt_no_push", 64'(if_valid), 64'(0));
    check("halt_pc_held", 64'(imem_addr), 64'(4));
    do_redirect(AW'(0));
    check("resume_halted", 64'(halted), 64'(0));
    expect_seq(AW'(0), 3);
    drain(nt);
    check("resume_cycles", 64'(nt), 64'(4));
    halt_mode = 1'b0;
`endif

    // Asynchronous reset mid-stream with two entries buffered
    do_reset();
    pulse_start();
    tick();
    tick();
    tick();
    check("pre_rst_valid", 64'(if_valid), 64'(1));
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", 64'(if_valid), 64'(0));
    check("async_rst_addr", 64'(imem_addr), 64'(0));
    check("async_rst_pc", 64'(if_pc), 64'(0));
    exp_q.delete();
    #1;
    rst_n = 1'b1;
    tick();
    tick();
    tick();
    check("post_rst_idle_valid", 64'(if_valid), 64'(0));
    check("post_rst_idle_addr", 64'(imem_addr), 64'(0));
    pulse_start();
    expect_seq(AW'(0), 1);
    drain(nt);
    check("restart_cycles", 64'(nt), 64'(2));

    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
